// File: rtl/dff_chain_arbiter.sv
// dff_chain_arbiter
//   Shares one external serial DFF chain among NUM_REQ requesters. A
//   round-robin arbiter picks a requester, latches its word and shifts it
//   MSB-first into chain stage 0. The chain is cleared between frames. A
//   one-cycle frame_done pulse marks the cycle in which the whole frame sits
//   in the chain.
//
//   Optional feature macro: PARITY_EN
//     When defined, an even-parity bit (XOR of the word) follows the LSB. The
//     frame is then WIDTH+1 bits long, and the chain must have WIDTH+1 stages.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          per-requester level request
//   req_data     requester i's word at [i*WIDTH +: WIDTH]
//   gnt          one-hot grant pulse, high in the first SHIFT cycle
//   chain_d      serial bit into chain stage 0
//   chain_clr    clear for every chain stage (high while IDLE)
//   busy         frame in progress (SHIFT or DONE)
//   frame_done   chain holds the complete frame this cycle
//   frame_owner  index of the current or last granted requester
module dff_chain_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     chain_d,
  output logic                     chain_clr,
  output logic                     busy,
  output logic                     frame_done,
  output logic [IDW-1:0]           frame_owner
);

`ifdef PARITY_EN
  localparam int SHIFT_LEN = WIDTH + 1;
`else
  localparam int SHIFT_LEN = WIDTH;
`endif
  localparam int CW = $clog2(SHIFT_LEN + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [SHIFT_LEN-1:0] sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;

  logic                 any_req;
  logic [IDW-1:0]       win;
  logic [WIDTH-1:0]     win_word;
  logic [SHIFT_LEN-1:0] win_frame;

  function automatic int wrap(input int v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  // Round-robin search starting one past the last winner. The first hit wins.
  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    win_word = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!any_req && req[wrap(int'(last_q) + i)]) begin
        any_req  = 1'b1;
        win      = IDW'(wrap(int'(last_q) + i));
        win_word = req_data[wrap(int'(last_q) + i)*WIDTH +: WIDTH];
      end
    end
  end

`ifdef PARITY_EN
  assign win_frame = {win_word, ^win_word};
`else
  assign win_frame = win_word;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    gnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_SHIFT;
          sr_d    = win_frame;
          cnt_d   = '0;
          last_d  = win;
          owner_d = win;
          gnt_d   = NUM_REQ'(1) << win;
        end
      end
      ST_SHIFT: begin
        sr_d  = {sr_q[SHIFT_LEN-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SHIFT_LEN - 1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

  // All outputs decode registered state, so an async reset reaches them at once.
  assign gnt         = gnt_q;
  assign chain_d     = (state_q == ST_SHIFT) & sr_q[SHIFT_LEN-1];
  assign chain_clr   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = (state_q == ST_DONE);
  assign frame_owner = owner_q;

endmodule
